mul_iter: RTL and testbench

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter.sv | 115 +++++++++++
 tb/tb_mul_iter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// Iterative radix-4 multiplier: one 2-bit multiplier digit per CALC cycle, W/2 cycles per product.
// Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude core); unsigned otherwise.
module mul_iter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mul_en,
    input  logic [W-1:0]   mul_a,
    input  logic [W-1:0]   mul_b,
    output logic [2*W:0]   mul_prod,
    output logic           mul_valid,
    output logic           mul_busy,
    output logic           mul_ovr
);
    localparam int CW = $clog2(W/2) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [2*W-1:0]  acc_reg;
    logic [CW-1:0]   cnt_reg;

    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W+1:0]    a_ext;
    logic [W+1:0]    multiple;
    logic [2*W-1:0]  partial;
    logic [2*W-1:0]  acc_next;
    logic [2*W:0]    prod_next;
    logic            last_digit;

`ifdef MUL_SIGNED_EN
    logic            neg_reg;

    // The most negative operand's magnitude still fits in W unsigned bits.
    assign a_mag     = mul_a[W-1] ? -mul_a : mul_a;
    assign b_mag     = mul_b[W-1] ? -mul_b : mul_b;
    assign prod_next = neg_reg ? -{1'b0, acc_next} : {1'b0, acc_next};
`else
    assign a_mag     = mul_a;
    assign b_mag     = mul_b;
    assign prod_next = {1'b0, acc_next};
`endif

    assign a_ext = {2'b00, a_reg};

    always_comb begin
        multiple = '0;
        case (b_reg[1:0])
            2'd0:    multiple = '0;
            2'd1:    multiple = a_ext;
            2'd2:    multiple = a_ext << 1;
            default: multiple = a_ext + (a_ext << 1);
        endcase
    end

    // b_reg is consumed LSB first; the counter supplies the digit weight.
    assign partial    = {{(W-2){1'b0}}, multiple} << {cnt_reg, 1'b0};
    assign acc_next   = acc_reg + partial;
    assign last_digit = (cnt_reg == CW'(W/2 - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            mul_prod  <= '0;
            mul_valid <= 1'b0;
            mul_busy  <= 1'b0;
            mul_ovr   <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_reg   <= 1'b0;
`endif
        end else begin
            mul_valid <= 1'b0;
            mul_ovr   <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (mul_en) begin
                        state_reg <= CALC;
                        a_reg     <= a_mag;
                        b_reg     <= b_mag;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        mul_busy  <= 1'b1;
`ifdef MUL_SIGNED_EN
                        neg_reg   <= mul_a[W-1] ^ mul_b[W-1];
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    // Requests while busy are dropped and flagged.
                    mul_ovr <= mul_en;
                    acc_reg <= acc_next;
                    b_reg   <= b_reg >> 2;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_digit) begin
                        state_reg <= DONE;
                        mul_busy  <= 1'b0;
                        mul_valid <= 1'b1;
                        mul_prod  <= prod_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter (W=16); follows the build's MUL_SIGNED_EN setting.
module tb_mul_iter;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mul_en;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W:0]   mul_prod;
    logic           mul_valid;
    logic           mul_busy;
    logic           mul_ovr;

    int n_assert = 0;
    int n_fail   = 0;

    mul_iter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_prod  (mul_prod),
        .mul_valid (mul_valid),
        .mul_busy  (mul_busy),
        .mul_ovr   (mul_ovr)
    );

    always #5 clk = ~clk;

    // Reference product straight from integer arithmetic.
    function automatic logic [2*W:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
`ifdef MUL_SIGNED_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'({48'd0, a}) * longint'({48'd0, b});
`endif
        return p[2*W:0];
    endfunction

    task automatic chk(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge; returns at the falling edge inside the DONE cycle.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int ovr_at);
        logic [2*W:0] exp;
        exp    = ref_prod(a, b);
        mul_en = 1'b1;
        mul_a  = a;
        mul_b  = b;
        @(posedge clk);
        for (int c = 1; c <= W/2; c++) begin
            @(negedge clk);
            mul_en = (c == ovr_at);
            mul_a  = (c == ovr_at) ? W'(2) : W'($urandom);
            mul_b  = (c == ovr_at) ? W'(2) : W'($urandom);
            chk("busy_calc",  mul_busy,  1);
            chk("valid_calc", mul_valid, 0);
            chk("ovr_calc",   mul_ovr,   (c == ovr_at + 1) ? 1 : 0);
            @(posedge clk);
        end
        @(negedge clk);
        mul_en = 1'b0;
        chk("valid_done", mul_valid, 1);
        chk("busy_done",  mul_busy,  0);
        chk("prod_done",  mul_prod,  exp);
        $display("txn a=0x%h b=0x%h prod=0x%h exp=0x%h", a, b, mul_prod, exp);
    endtask

    task automatic idle_check(input int cycles, input logic [2*W:0] held);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("valid_idle", mul_valid, 0);
            chk("busy_idle",  mul_busy,  0);
            chk("ovr_idle",   mul_ovr,   0);
            chk("prod_hold",  mul_prod,  held);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        mul_en = 1'b0;
        mul_a  = '0;
        mul_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prod",  mul_prod,  0);
        chk("rst_valid", mul_valid, 0);
        chk("rst_busy",  mul_busy,  0);
        chk("rst_ovr",   mul_ovr,   0);

        // First request accepted on the first edge with reset released.
        rst_n = 1'b1;
        run_mul(16'd3, 16'd5, -1);
        idle_check(3, ref_prod(16'd3, 16'd5));

        run_mul(16'hFFFF, 16'hFFFF, -1);
        run_mul(16'h0000, 16'h1234, -1);
        run_mul(16'h8000, 16'h8000, -1);
        run_mul(16'h8000, 16'h0001, -1);
        run_mul(16'h0001, 16'h8000, -1);
        idle_check(2, ref_prod(16'h0001, 16'h8000));

        // Dropped request during CALC cycle 3.
        run_mul(16'd7, 16'd9, 3);
        idle_check(2, ref_prod(16'd7, 16'd9));

        // Back-to-back: next request issued in the DONE cycle.
        run_mul(16'd7, 16'd9, -1);
        run_mul(16'd10, 16'd10, -1);
        idle_check(1, ref_prod(16'd10, 16'd10));

        // Reset mid-CALC aborts; mul_en during the reset edge is discarded.
        mul_en = 1'b1;
        mul_a  = 16'd7;
        mul_b  = 16'd9;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mul_en = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        rst_n  = 1'b0;
        mul_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mul_en = 1'b0;
        chk("abort_prod",  mul_prod,  0);
        chk("abort_valid", mul_valid, 0);
        chk("abort_busy",  mul_busy,  0);
        chk("abort_ovr",   mul_ovr,   0);
        rst_n = 1'b1;
        idle_check(10, '0);
        @(negedge clk);
        run_mul(16'd2, 16'd3, -1);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) ra = {1'b1, 15'($urandom)};
            run_mul(ra, rb, (i % 4 == 1) ? 1 + (i % 6) : -1);
            if (i % 3 == 0) idle_check(1, ref_prod(ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end
endmodule
